// File: rtl/image_weight_engine.sv
// Frame-level weighted channel reduction (e.g. RGB to grayscale) with its own read/write address FSM.
// Build option: define ROUND_NEAREST_EN for round-half-up instead of truncation before saturation.
module image_weight_engine #(
    parameter int IMAGE_HEIGHT      = 5,
    parameter int IMAGE_WIDTH       = 5,
    parameter int NUM_CHANNELS      = 3,
    parameter int DATA_COLOR_WIDTH  = 8,
    parameter int FIXED_POINT_WIDTH = 32,
    parameter int POINT_POSITION    = 16,
    parameter int ADDR_WIDTH        = 6
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [NUM_CHANNELS*FIXED_POINT_WIDTH-1:0]   scales,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        rd_en,
    output logic [ADDR_WIDTH-1:0]                       rd_addr,
    input  logic [NUM_CHANNELS*DATA_COLOR_WIDTH-1:0]    rd_data,
    output logic                                        wr_en,
    output logic [ADDR_WIDTH-1:0]                       wr_addr,
    output logic [DATA_COLOR_WIDTH-1:0]                 wr_data,
    output logic [ADDR_WIDTH:0]                         sat_count
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one source read per cycle, addresses 0..N-1
    // DRAIN | reads finished, pipeline emptying
    // DONE  | one-cycle done pulse; a held start chains the next frame
    localparam int N_PIX  = IMAGE_HEIGHT * IMAGE_WIDTH;
    localparam int PROD_W = DATA_COLOR_WIDTH + FIXED_POINT_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(NUM_CHANNELS) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_PIX - 1);
    localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((1 << DATA_COLOR_WIDTH) - 1);
`ifdef ROUND_NEAREST_EN
    localparam logic [SUM_W-1:0] RND_BIAS = (POINT_POSITION > 0) ?
        (SUM_W'(1) << (POINT_POSITION > 0 ? POINT_POSITION - 1 : 0)) : '0;
`else
    localparam logic [SUM_W-1:0] RND_BIAS = '0;
`endif

    if (N_PIX > (1 << ADDR_WIDTH)) begin : g_addr_chk
        $error("image_weight_engine: IMAGE_HEIGHT*IMAGE_WIDTH exceeds 2**ADDR_WIDTH");
    end
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_chan_chk
        $error("image_weight_engine: NUM_CHANNELS must be 1..8");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic                                   busy_q, busy_d;
    logic                                   done_q, done_d;
    logic                                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]                  rd_addr_q, rd_addr_d;
    logic [NUM_CHANNELS*FIXED_POINT_WIDTH-1:0] scales_q, scales_d;
    logic                                   data_vld_q, data_vld_d;
    logic [ADDR_WIDTH-1:0]                  data_addr_q, data_addr_d;
    logic [PROD_W-1:0]                      prod_q [NUM_CHANNELS];
    logic [PROD_W-1:0]                      prod_d [NUM_CHANNELS];
    logic                                   prod_vld_q, prod_vld_d;
    logic [ADDR_WIDTH-1:0]                  prod_addr_q, prod_addr_d;
    logic                                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]                  wr_addr_q, wr_addr_d;
    logic [DATA_COLOR_WIDTH-1:0]            wr_data_q, wr_data_d;
    logic [ADDR_WIDTH:0]                    sat_count_q, sat_count_d;
    logic [SUM_W-1:0]                       sum_raw, sum_shift;
    logic                                   sum_sat;
    logic                                   accept;

    always_comb begin
        sum_raw = RND_BIAS;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum_raw = sum_raw + SUM_W'(prod_q[c]);
        end
        sum_shift = sum_raw >> POINT_POSITION;
        sum_sat   = sum_shift > PIX_MAX;
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        scales_d    = scales_q;
        data_vld_d  = rd_en_q;
        data_addr_d = rd_addr_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            prod_d[c] = PROD_W'(rd_data[c*DATA_COLOR_WIDTH +: DATA_COLOR_WIDTH])
                      * PROD_W'(scales_q[c*FIXED_POINT_WIDTH +: FIXED_POINT_WIDTH]);
        end
        prod_vld_d  = data_vld_q;
        prod_addr_d = data_addr_q;
        wr_en_d     = prod_vld_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        sat_count_d = sat_count_q;
        accept      = 1'b0;
        if (prod_vld_q) begin
            wr_addr_d = prod_addr_q;
            wr_data_d = sum_sat ? '1 : sum_shift[DATA_COLOR_WIDTH-1:0];
            if (sum_sat) begin
                sat_count_d = sat_count_q + (ADDR_WIDTH+1)'(1);
            end
        end
        case (state_q)
            S_IDLE: accept = start;
            S_RUN: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
            // Leave once the final write is the only stage left, so done lands right after it.
            S_DRAIN: begin
                if (!data_vld_q && !prod_vld_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                accept = start;
                if (!start) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d     = S_RUN;
            busy_d      = 1'b1;
            rd_en_d     = 1'b1;
            rd_addr_d   = '0;
            scales_d    = scales;
            sat_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            scales_q    <= '0;
            data_vld_q  <= 1'b0;
            data_addr_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) prod_q[c] <= '0;
            prod_vld_q  <= 1'b0;
            prod_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            sat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            scales_q    <= scales_d;
            data_vld_q  <= data_vld_d;
            data_addr_q <= data_addr_d;
            for (int c = 0; c < NUM_CHANNELS; c++) prod_q[c] <= prod_d[c];
            prod_vld_q  <= prod_vld_d;
            prod_addr_q <= prod_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign sat_count = sat_count_q;
endmodule
